// File: rtl/conv_mac_array.sv
// rtl/conv_mac_array.sv - KxK signed dot-product MAC, 3-stage pipeline with global stall.
// Optional: define CONV_MAC_SATURATE_EN to clamp the result instead of wrapping.
module conv_mac_array #(
    parameter int DATA_WIDTH = 32,
    parameter int K          = 3,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(K*K)
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        wgt_wr_en,
    input  logic [((K*K > 1) ? $clog2(K*K) : 1)-1:0]    wgt_addr,
    input  logic [DATA_WIDTH-1:0]                       wgt_data,
    input  logic                                        win_valid,
    output logic                                        win_ready,
    input  logic [K*K*DATA_WIDTH-1:0]                   win_data,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [DATA_WIDTH-1:0]                       out_data,
    output logic                                        busy
);
    localparam int NTAP = K*K;
    localparam int AW   = (NTAP > 1) ? $clog2(NTAP) : 1;
    localparam int PW   = 2*DATA_WIDTH;

    logic [DATA_WIDTH-1:0]        wgt_q  [NTAP];
    logic [DATA_WIDTH-1:0]        wgt_d  [NTAP];
    logic signed [PW-1:0]         prod_q [NTAP];
    logic signed [PW-1:0]         prod_d [NTAP];
    logic                         s1_valid_q, s1_valid_d;
    logic signed [ACC_WIDTH-1:0]  sum_q, sum_d;
    logic                         s2_valid_q, s2_valid_d;
    logic [DATA_WIDTH-1:0]        out_data_q, out_data_d;
    logic                         out_valid_q, out_valid_d;

    logic                         adv;
    logic signed [PW-1:0]         op_w, op_x;
    logic signed [ACC_WIDTH-1:0]  tree_sum;
    logic [DATA_WIDTH-1:0]        res;

    assign adv       = !out_valid_q || out_ready;
    assign win_ready = adv;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = s1_valid_q || s2_valid_q || out_valid_q;

    // Weight writes ignore the stall; addresses past the last tap match no entry.
    always_comb begin
        for (int t = 0; t < NTAP; t++) begin
            wgt_d[t] = wgt_q[t];
            if (wgt_wr_en && (wgt_addr == AW'(t))) begin
                wgt_d[t] = wgt_data;
            end
        end
    end

    // S1 samples the current weight registers, so a same-cycle write is not seen.
    always_comb begin
        op_w = '0;
        op_x = '0;
        for (int t = 0; t < NTAP; t++) begin
            op_w      = PW'($signed(wgt_q[t]));
            op_x      = PW'($signed(win_data[t*DATA_WIDTH +: DATA_WIDTH]));
            prod_d[t] = adv ? (op_w * op_x) : prod_q[t];
        end
        s1_valid_d = adv ? win_valid : s1_valid_q;
    end

    always_comb begin
        tree_sum = '0;
        for (int t = 0; t < NTAP; t++) begin
            tree_sum = tree_sum + ACC_WIDTH'(prod_q[t]);
        end
        sum_d      = adv ? tree_sum : sum_q;
        s2_valid_d = adv ? s1_valid_q : s2_valid_q;
    end

`ifdef CONV_MAC_SATURATE_EN
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    always_comb begin
        if (sum_q > SAT_MAX) begin
            res = SAT_MAX[DATA_WIDTH-1:0];
        end else if (sum_q < SAT_MIN) begin
            res = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            res = sum_q[DATA_WIDTH-1:0];
        end
    end
`else
    logic unused_sum_hi;
    assign unused_sum_hi = ^sum_q[ACC_WIDTH-1:DATA_WIDTH];

    always_comb begin
        res = sum_q[DATA_WIDTH-1:0];
    end
`endif

    always_comb begin
        out_valid_d = adv ? s2_valid_q : out_valid_q;
        out_data_d  = (adv && s2_valid_q) ? res : out_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int t = 0; t < NTAP; t++) begin
                wgt_q[t]  <= '0;
                prod_q[t] <= '0;
            end
            s1_valid_q  <= 1'b0;
            sum_q       <= '0;
            s2_valid_q  <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            wgt_q       <= wgt_d;
            prod_q      <= prod_d;
            s1_valid_q  <= s1_valid_d;
            sum_q       <= sum_d;
            s2_valid_q  <= s2_valid_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_conv_mac_array.sv
// tb/tb_conv_mac_array.sv - randomized and directed bench for conv_mac_array against a queue model.
module tb_conv_mac_array;
    localparam int DW = 32;
    localparam int K  = 3;
    localparam int NT = K*K;
    localparam int AW = $clog2(NT);

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             wgt_wr_en = 1'b0;
    logic [AW-1:0]    wgt_addr  = '0;
    logic [DW-1:0]    wgt_data  = '0;
    logic             win_valid = 1'b0;
    logic             win_ready;
    logic [NT*DW-1:0] win_data  = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [DW-1:0]    out_data;
    logic             busy;

    always #5 clk = ~clk;

    conv_mac_array #(.DATA_WIDTH(DW), .K(K)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wgt_wr_en (wgt_wr_en),
        .wgt_addr  (wgt_addr),
        .wgt_data  (wgt_data),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .win_data  (win_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] mw [NT];
    logic [DW-1:0] exp_q [$];
    int            acc_cyc_q [$];
    logic [DW-1:0] got_q [$];
    int            got_cyc_q [$];
    int            cyc = 0;
    int            acc_cnt = 0;
    int            last_lat = 0;
    bit            mon_en = 1'b0;
    bit            prev_hold = 1'b0;
    logic [DW-1:0] prev_data = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Dot product from the weights as they stand before this cycle's write.
    function automatic logic [DW-1:0] ref_dot(input logic [NT*DW-1:0] win);
        logic signed [2*DW+7:0] s;
        logic signed [2*DW+7:0] a;
        logic signed [2*DW+7:0] b;
        s = '0;
        for (int t = 0; t < NT; t++) begin
            a = $signed(mw[t]);
            b = $signed(win[t*DW +: DW]);
            s = s + a * b;
        end
`ifdef CONV_MAC_SATURATE_EN
        if (s > 72'sh7FFFFFFF) return 32'h7FFFFFFF;
        if (s < -72'sh80000000) return 32'h80000000;
`endif
        return s[DW-1:0];
    endfunction

    function automatic logic [NT*DW-1:0] rand_win();
        logic [NT*DW-1:0] w;
        for (int t = 0; t < NT; t++) w[t*DW +: DW] = $urandom;
        return w;
    endfunction

    function automatic logic [NT*DW-1:0] all_val(input logic [DW-1:0] v);
        logic [NT*DW-1:0] w;
        for (int t = 0; t < NT; t++) w[t*DW +: DW] = v;
        return w;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (mon_en && rst_n) begin
            chk("win_ready", win_ready, !out_valid || out_ready);
            chk("busy", busy, exp_q.size() != 0);
            if (prev_hold) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, prev_data);
            end
            if (out_valid && exp_q.size() == 0) begin
                chk("spurious_out", out_valid, 0);
            end else if (out_valid && out_ready) begin
                chk("out_data", out_data, exp_q[0]);
                last_lat = cyc - acc_cyc_q[0];
                void'(exp_q.pop_front());
                void'(acc_cyc_q.pop_front());
                got_q.push_back(out_data);
                got_cyc_q.push_back(cyc);
            end
            if (win_valid && win_ready) begin
                exp_q.push_back(ref_dot(win_data));
                acc_cyc_q.push_back(cyc);
                acc_cnt++;
            end
            if (wgt_wr_en && wgt_addr < NT) mw[wgt_addr] = wgt_data;
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        win_valid = 1'b0;
        wgt_wr_en = 1'b0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        chk("drain_timeout", exp_q.size(), 0);
        tick();
    endtask

    task automatic do_reset();
        mon_en    = 1'b0;
        rst_n     = 1'b0;
        win_valid = 1'b0;
        wgt_wr_en = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_data", out_data, 0);
        exp_q.delete();
        acc_cyc_q.delete();
        prev_hold = 1'b0;
        for (int t = 0; t < NT; t++) mw[t] = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        chk("ready_after_rst", win_ready, 1);
    endtask

    task automatic write_wgt(input int addr, input logic [DW-1:0] val);
        wgt_wr_en = 1'b1;
        wgt_addr  = AW'(addr);
        wgt_data  = val;
        tick();
        wgt_wr_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  rdy_low;
        int  a0;
        int  offered;
        bit  acc;

        do_reset();

        // Weights 1..9, window of 2s -> 90 three cycles after acceptance.
        out_ready = 1'b1;
        for (int t = 0; t < NT; t++) write_wgt(t, DW'(t + 1));
        got_q.delete();
        win_valid = 1'b1;
        win_data  = all_val(32'd2);
        tick();
        win_valid = 1'b0;
        drain();
        chk("dot90_count", got_q.size(), 1);
        if (got_q.size() == 1) chk("dot90_value", got_q[0], 90);
        chk("dot90_latency", last_lat, 3);

        // Ten back-to-back windows.
        got_q.delete();
        got_cyc_q.delete();
        rdy_low = 0;
        for (int i = 0; i < 10; i++) begin
            win_valid = 1'b1;
            win_data  = rand_win();
            @(negedge clk);
            if (!win_ready) rdy_low++;
            tick();
        end
        win_valid = 1'b0;
        drain();
        chk("b2b_count", got_cyc_q.size(), 10);
        if (got_cyc_q.size() == 10) chk("b2b_consecutive", got_cyc_q[9] - got_cyc_q[0], 9);
        chk("b2b_ready_low", rdy_low, 0);

        // Output stalled for five cycles, four windows offered.
        out_ready = 1'b0;
        a0        = acc_cnt;
        offered   = 1;
        win_valid = 1'b1;
        win_data  = rand_win();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            acc = win_ready;
            tick();
            if (acc) begin
                offered++;
                if (offered <= 4) win_data = rand_win();
                else win_valid = 1'b0;
            end
        end
        chk("stall_accepted", acc_cnt - a0, 3);
        chk("stall_ready_low", win_ready, 0);
        chk("stall_out_valid", out_valid, 1);
        drain();

        // Tap-0 write in the same cycle as window A; B and C see 100; out-of-range write ignored.
        got_q.delete();
        win_valid = 1'b1;
        win_data  = all_val(32'd1);
        wgt_wr_en = 1'b1;
        wgt_addr  = 4'd0;
        wgt_data  = 32'd100;
        tick();
        win_valid = 1'b0;
        wgt_wr_en = 1'b0;
        tick();
        win_valid = 1'b1;
        wgt_wr_en = 1'b1;
        wgt_addr  = 4'd12;
        wgt_data  = 32'd555;
        tick();
        wgt_wr_en = 1'b0;
        tick();
        win_valid = 1'b0;
        drain();
        chk("wupd_count", got_q.size(), 3);
        if (got_q.size() == 3) begin
            chk("wupd_A_old", got_q[0], 45);
            chk("wupd_B_new", got_q[1], 144);
            chk("wupd_C_oob", got_q[2], 144);
        end

        // Full-scale positive operands.
        for (int t = 0; t < NT; t++) write_wgt(t, 32'h7FFFFFFF);
        got_q.delete();
        win_valid = 1'b1;
        win_data  = all_val(32'h7FFFFFFF);
        tick();
        win_valid = 1'b0;
        drain();
        chk("max_count", got_q.size(), 1);
`ifdef CONV_MAC_SATURATE_EN
        if (got_q.size() == 1) chk("max_saturate", got_q[0], 32'h7FFFFFFF);
`else
        if (got_q.size() == 1) chk("max_wrap", got_q[0], 32'h00000009);
`endif

        // Random traffic with back-pressure and weight updates.
        for (int i = 0; i < 400; i++) begin
            win_valid = ($urandom_range(0, 3) != 0);
            win_data  = rand_win();
            out_ready = ($urandom_range(0, 3) != 0);
            wgt_wr_en = ($urandom_range(0, 5) == 0);
            wgt_addr  = AW'($urandom_range(0, 15));
            wgt_data  = $urandom;
            tick();
        end
        drain();

        // Reset with two windows in flight.
        out_ready = 1'b1;
        win_valid = 1'b1;
        win_data  = rand_win();
        tick();
        win_data  = rand_win();
        tick();
        win_valid = 1'b0;
        #2;
        do_reset();
        repeat (10) tick();
        chk("post_rst_idle", out_valid, 0);
        got_q.delete();
        win_valid = 1'b1;
        win_data  = all_val(32'd1);
        tick();
        win_valid = 1'b0;
        drain();
        chk("post_rst_count", got_q.size(), 1);
        if (got_q.size() == 1) chk("post_rst_zero_wgt", got_q[0], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv_mac_array.md
CONV_MAC_ARRAY -- requirements
Module: conv_mac_array

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32; width of weights, window pixels and result.
REQ-002 SHALL have parameter K, default 3; kernel side length, K*K taps, legal range 1..7.
REQ-003 SHALL have parameter ACC_WIDTH, default 2*DATA_WIDTH+$clog2(K*K); internal sum width.
REQ-004 SHALL have port clk, input, 1; the single clock, rising-edge.
REQ-005 SHALL have port rst_n, input, 1; asynchronous, active-low reset.
REQ-006 SHALL have port wgt_wr_en, input, 1; writes one weight this cycle.
REQ-007 SHALL have port wgt_addr, input, $clog2(K*K); tap index, row-major, 0..K*K-1.
REQ-008 SHALL have port wgt_data, input, DATA_WIDTH; signed weight value.
REQ-009 SHALL have port win_valid, input, 1; window present.
REQ-010 SHALL have port win_ready, output, 1; window accepted when win_valid and win_ready.
REQ-011 SHALL have port win_data, input, K*K*DATA_WIDTH; signed pixels, tap t at bits [t*DATA_WIDTH +: DATA_WIDTH].
REQ-012 SHALL have port out_valid, output, 1; result present.
REQ-013 SHALL have port out_ready, input, 1; result consumed when out_valid and out_ready.
REQ-014 SHALL have port out_data, output, DATA_WIDTH; signed dot product.
REQ-015 SHALL have port busy, output, 1; high when any pipeline stage holds valid data.

Function
REQ-016 SHALL compute out_data = sum over t of wgt[t]*win_data[t], signed two's complement, full-precision products, ACC_WIDTH sum.
REQ-017 SHALL use three register stages: S1 products, S2 adder-tree sum, S3 output register; latency 3 cycles from acceptance to out_valid, no stalls.
REQ-018 SHALL advance all stages when adv = !out_valid || out_ready; otherwise every stage holds.
REQ-019 SHALL drive win_ready = adv, combinationally; no dependence on win_valid.
REQ-020 SHALL sustain one window per cycle while out_ready stays high.
REQ-021 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-022 SHALL write wgt[wgt_addr] on every clk edge with wgt_wr_en=1, regardless of adv; wgt_addr >= K*K is ignored.
REQ-023 SHALL use pre-write weights for a window accepted in the same cycle as a weight write; new weight applies from the next accepted window.
REQ-024 SHALL not alter in-flight results when weights change (products captured in S1).
REQ-025 SHALL drive busy = S1 valid or S2 valid or out_valid.

Reset
REQ-026 SHALL, on rst_n low, asynchronously clear all stage valid flags, out_valid=0, out_data=0, busy=0, all weights=0.
REQ-027 SHALL drop any in-flight window on reset mid-operation; no result emerges for it after release.
REQ-028 SHALL have win_ready=1 in the first cycle after rst_n deasserts.

Configuration
REQ-029 SHALL, with CONV_MAC_SATURATE_EN defined, clamp the ACC_WIDTH sum to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] in S3.
REQ-030 SHALL, without CONV_MAC_SATURATE_EN, output the low DATA_WIDTH bits of the sum (wrap-around).

Verification
REQ-031 SHALL cover: DATA_WIDTH=32,K=3, weights 1..9, window all 2, out_ready=1 -> out_data=90 exactly 3 cycles after acceptance.
REQ-032 SHALL cover: 10 back-to-back windows, out_ready=1 -> 10 results on consecutive cycles, win_ready never low.
REQ-033 SHALL cover: out_ready=0 for 5 cycles with 4 windows offered -> 3 accepted, win_ready low once pipeline full, results held stable, then drained in order.
REQ-034 SHALL cover: wgt_wr_en to tap 0 (value 100) in the acceptance cycle of window A and before window B -> A uses old weight, B uses 100.
REQ-035 SHALL cover: all weights and pixels 0x7FFFFFFF -> saturate build gives 0x7FFFFFFF, wrap build gives low 32 bits of 9*(2^31-1)^2.
REQ-036 SHALL cover: rst_n pulsed low with 2 windows in flight -> out_valid=0 and busy=0 immediately, no stale result after release.
